// File: rtl/seq_pkg.sv
// Shared types and widths for the sequence stepper.
package seq_pkg;

    localparam int unsigned SEQ_W  = 6;
    localparam int unsigned STEP_W = 4;
    localparam int unsigned FREQ_W = 3;
    localparam int unsigned ADDR_W = SEQ_W + STEP_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/key_edge.sv
// Per-bit 2-flop synchronizer and falling-edge detector for active-low buttons.
module key_edge #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] press
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign press = prev & ~sync2;

endmodule

// File: rtl/seq_stepper.sv
// Play/pause/stop stepper producing seq_num, freq_num and rom_addr for the tone ROM.
// Define SEQ_STEPPER_LOOP_EN to loop at step 15 instead of returning to IDLE.
module seq_stepper
    import seq_pkg::*;
#(
    parameter int unsigned BASE_TICKS = 12_500_000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [3:0]        KEY,
    input  logic [2:0]        SW,
    output logic [SEQ_W-1:0]  seq_num,
    output logic [FREQ_W-1:0] freq_num,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              step_pulse,
    output logic              playing
);

    localparam int unsigned CNT_W = (BASE_TICKS > 1) ? $clog2(BASE_TICKS) : 1;

    logic [3:0]        key_press;
    logic [FREQ_W-1:0] sw_s1;
    logic [FREQ_W-1:0] sw_s2;

    state_t            state, state_n;
    logic [STEP_W-1:0] step, step_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [SEQ_W-1:0]  seq_n;
    logic              pulse_n;

    logic [31:0]       period;
    logic [CNT_W-1:0]  term;
    logic              do_play, do_stop, do_next, do_prev, tempo_change;

    key_edge #(.WIDTH(4)) u_key_edge (
        .clk   (CLOCK_50),
        .rst   (reset),
        .raw   (KEY),
        .press (key_press)
    );

    assign do_play      = key_press[0];
    assign do_stop      = key_press[1];
    assign do_next      = key_press[2];
    assign do_prev      = key_press[3];
    assign tempo_change = (sw_s2 != freq_num);

    always_comb begin
        period = 32'(BASE_TICKS) >> freq_num;
        if (period == 32'd0)
            period = 32'd1;
        term = CNT_W'(period - 32'd1);
    end

    // Priority: stop, then play/pause, then sequence change, then normal counting.
    always_comb begin
        state_n = state;
        step_n  = step;
        cnt_n   = cnt;
        seq_n   = seq_num;
        pulse_n = 1'b0;
        if (do_stop) begin
            state_n = IDLE;
            step_n  = '0;
            cnt_n   = '0;
        end else if (do_play) begin
            case (state)
                IDLE: begin
                    state_n = PLAY;
                    step_n  = '0;
                    cnt_n   = '0;
                end
                PLAY:    state_n = PAUSE;
                PAUSE:   state_n = PLAY;
                default: state_n = IDLE;
            endcase
        end else if (do_next ^ do_prev) begin
            seq_n  = do_next ? seq_num + 1'b1 : seq_num - 1'b1;
            step_n = '0;
            cnt_n  = '0;
        end else if (state == PLAY) begin
            if (cnt == term) begin
                cnt_n   = '0;
                pulse_n = 1'b1;
                if (step != '1) begin
                    step_n = step + 1'b1;
                end else begin
                    step_n = '0;
`ifdef SEQ_STEPPER_LOOP_EN
                    state_n = PLAY;
`else
                    state_n = IDLE;
`endif
                end
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
        // A tempo change restarts the count but never blocks a step already due.
        if (tempo_change)
            cnt_n = '0;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sw_s1      <= '0;
            sw_s2      <= '0;
            freq_num   <= '0;
            state      <= IDLE;
            step       <= '0;
            cnt        <= '0;
            seq_num    <= '0;
            step_pulse <= 1'b0;
            playing    <= 1'b0;
        end else begin
            sw_s1      <= SW;
            sw_s2      <= sw_s1;
            freq_num   <= sw_s2;
            state      <= state_n;
            step       <= step_n;
            cnt        <= cnt_n;
            seq_num    <= seq_n;
            step_pulse <= pulse_n;
            playing    <= (state_n == PLAY);
        end
    end

    assign rom_addr = {seq_num, step};

endmodule
